// File: rtl/ram_rmw_ctrl.sv
// ram_rmw_ctrl: command sequencer in front of a single-port RA1SH SRAM.
// It turns READ / WRITE / XOR-accumulate / read-and-clear commands into
// legal CEN/WEN strobe sequences and returns read or pre-modification data.
module ram_rmw_ctrl #(
    parameter int AddressWidth = 11,
    parameter int DataWidth    = 144,
    parameter int Deapth       = 2048
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic [DataWidth-1:0]    req_data,
    output logic                    rsp_valid,
    output logic [DataWidth-1:0]    rsp_data,
    output logic                    busy,
    output logic [AddressWidth-1:0] sram_A,
    output logic [DataWidth-1:0]    sram_D,
    input  logic [DataWidth-1:0]    sram_Q,
    output logic                    sram_CEN,
    output logic                    sram_WEN,
    output logic                    sram_OEN
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RD_RSP = 2'b01,
        RMW_WR = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_XOR   = 2'b10,
        OP_RDCLR = 2'b11
    } op_e;

    // The address is used unmodified, so the depth must cover the full address space.
    if (Deapth != (1 << AddressWidth)) begin : g_depth_check
        $error("ram_rmw_ctrl: Deapth must equal 2**AddressWidth");
    end

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    op_e                     req_op_e;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0]    data_q, data_d;

    assign req_op_e = op_e'(req_op);

    // State and RMW latch registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state, SRAM strobes and response outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        busy      = 1'b0;
        sram_CEN  = 1'b1;
        sram_WEN  = 1'b1;
        sram_A    = '0;
        sram_D    = '0;
        sram_OEN  = RST;

        if (RST) begin
            // Reset drops any pending RMW write: the strobes stay quiet.
            state_d = IDLE;
            op_d    = OP_READ;
            addr_d  = '0;
            data_d  = '0;
        end else begin
            case (state_q)
                RMW_WR: begin
                    // Write-back half of XOR / RDCLR; Q holds the old word read last cycle.
                    busy      = 1'b1;
                    rsp_valid = 1'b1;
                    rsp_data  = sram_Q;
                    sram_CEN  = 1'b0;
                    sram_WEN  = 1'b0;
                    sram_A    = addr_q;
                    sram_D    = (op_q == OP_XOR) ? (sram_Q ^ data_q) : '0;
                    state_d   = IDLE;
                end
                default: begin
                    // IDLE and RD_RSP both accept; RD_RSP also presents the read word.
                    req_ready = 1'b1;
                    if (state_q == RD_RSP) begin
                        rsp_valid = 1'b1;
                        rsp_data  = sram_Q;
                    end
                    state_d = IDLE;
                    if (req_valid) begin
                        sram_CEN = 1'b0;
                        sram_A   = req_addr;
                        case (req_op_e)
                            OP_READ: begin
                                state_d = RD_RSP;
                            end
                            OP_WRITE: begin
                                sram_WEN = 1'b0;
                                sram_D   = req_data;
                            end
                            default: begin
                                state_d = RMW_WR;
                                op_d    = req_op_e;
                                addr_d  = req_addr;
                                data_d  = req_data;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
